// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned INSN_W = 32;
    localparam int unsigned PC_W   = 32;

    localparam logic [INSN_W-1:0] NOP_INSN = 32'h0;
    localparam logic [PC_W-1:0]   PC_RESET = 32'h0;

    typedef struct packed {
        logic [INSN_W-1:0] insn;
        logic [PC_W-1:0]   pc;
    } fetch_entry_t;

    // Sequential fetch advances one word, wrapping at 2^32.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(1);
    endfunction

endpackage

// File: rtl/insn_fifo.sv
// Synchronous DEPTH-entry FIFO of fetched {insn, pc} entries; flush beats push/pop.
module insn_fifo
    import fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  fetch_entry_t     i_data,
    output fetch_entry_t     o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // A push into a full buffer is only taken when the head leaves the same cycle.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clock) begin
        if (reset || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Storage carries no reset; occupancy alone says which slots are live.
    always_ff @(posedge clock) begin
        if (w_push && !i_flush && !reset) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, single outstanding imem read, redirect handling,
// and a small buffer feeding decode with {insn, pc}.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              stall,
    output logic              fd_valid,
    output logic [31:0]       fd_insn,
    output logic [31:0]       fd_pc,
    output logic [31:0]       fd_pc_plus1
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      r_pc;
    logic [31:0]      r_req_pc;
    logic             r_outstanding;
    logic             r_discard;

    fetch_entry_t     w_head;
    fetch_entry_t     w_push_data;
    logic [CNT_W-1:0] w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_have;
    logic             w_issue;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;

    // With one read in flight at most, issuing only while count < DEPTH keeps
    // count + outstanding within the buffer.
    assign w_issue  = !reset && !r_outstanding && !redirect_valid
                      && (w_count < CNT_W'(DEPTH));
    assign w_accept = imem_rvalid && r_outstanding;
    assign w_have   = !reset && !w_empty;
    assign w_pop    = w_have && !stall && !redirect_valid;
    assign w_push   = w_accept && !r_discard && !redirect_valid && (!w_full || w_pop);

    assign w_push_data = '{insn: imem_rdata, pc: r_req_pc};

    insn_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_data  (w_push_data),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Redirect outranks issue/response; a read still in flight when it lands
    // is marked for discard unless its data arrives in that same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc          <= PC_RESET;
            r_req_pc      <= PC_RESET;
            r_outstanding <= 1'b0;
            r_discard     <= 1'b0;
        end else if (redirect_valid) begin
            r_pc <= redirect_pc;
            if (r_outstanding) begin
                r_outstanding <= !imem_rvalid;
                r_discard     <= !imem_rvalid;
            end
        end else if (w_issue) begin
            r_pc          <= pc_inc(r_pc);
            r_req_pc      <= r_pc;
            r_outstanding <= 1'b1;
        end else if (w_accept) begin
            r_outstanding <= 1'b0;
            r_discard     <= 1'b0;
        end
    end

    assign imem_req    = w_issue;
    assign imem_addr   = r_pc[ADDR_W-1:0];

    assign fd_valid    = w_have;
    assign fd_insn     = w_have ? w_head.insn      : NOP_INSN;
    assign fd_pc       = w_have ? w_head.pc        : 32'h0;
    assign fd_pc_plus1 = w_have ? pc_inc(w_head.pc) : 32'h0;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios plus randomized stall/redirect/latency.
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DEPTH  = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rvalid = 1'b0;
    logic [31:0]       imem_rdata = 32'h0;
    logic              redirect_valid = 1'b0;
    logic [31:0]       redirect_pc = 32'h0;
    logic              stall = 1'b0;
    logic              fd_valid;
    logic [31:0]       fd_insn;
    logic [31:0]       fd_pc;
    logic [31:0]       fd_pc_plus1;

    fetch_stage #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .fd_valid       (fd_valid),
        .fd_insn        (fd_insn),
        .fd_pc          (fd_pc),
        .fd_pc_plus1    (fd_pc_plus1)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int                due;
        logic [ADDR_W-1:0] addr;
    } mem_req_t;

    mem_req_t    mem_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_next = 32'h0;
    int          lat = 1;
    int          data_mode = 0;
    int          pops = 0;
    int          total = 0;
    int          bad = 0;

    logic              last_req, last_valid, last_rvalid;
    logic [ADDR_W-1:0] last_addr;
    logic [31:0]       last_pc, last_insn, last_plus1;

    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a, input int mode);
        logic [31:0] w;
        w = 32'(a);
        if (mode == 0) return w;
        return (w * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: drive inputs, play memory, maintain the expected stream.
    task automatic step(input logic rst, input logic rv, input logic [31:0] rpc, input logic st);
        @(negedge clock);
        reset          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        stall          = st;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_q[0].addr, data_mode);
            mem_q.delete(0);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        if (rst) begin
            exp_q.delete();
            exp_next = PC_RESET;
        end else if (rv) begin
            exp_q.delete();
            exp_next = rpc;
        end
        while (exp_q.size() < 16) begin
            exp_q.push_back(exp_next);
            exp_next = exp_next + 32'd1;
        end
        #1;
        last_req    = imem_req;
        last_addr   = imem_addr;
        last_valid  = fd_valid;
        last_pc     = fd_pc;
        last_insn   = fd_insn;
        last_plus1  = fd_pc_plus1;
        last_rvalid = imem_rvalid;
        if (imem_req) mem_q.push_back('{due: cyc + lat, addr: imem_addr});
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic wait_req(input logic [ADDR_W-1:0] a, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            if (last_req && last_addr == a) hit = 1'b1;
        end
        check(name, 32'(hit), 32'd1);
    endtask

    task automatic wait_valid(input string name, input logic [31:0] pc_exp);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            if (last_valid) hit = 1'b1;
        end
        check({name, "_seen"}, 32'(hit), 32'd1);
        check({name, "_pc"}, last_pc, pc_exp);
    endtask

    // Monitor: every visible pop must be the next word of the sequential stream.
    logic        p_hold = 1'b0;
    logic [31:0] p_pc, p_insn;
    always @(negedge clock) begin
        logic [31:0] e;
        #2;
        if (reset) begin
            check("rst_valid", 32'(fd_valid), 32'd0);
            check("rst_insn", fd_insn, 32'h0);
            check("rst_pc", fd_pc, 32'h0);
            check("rst_plus1", fd_pc_plus1, 32'h0);
            check("rst_req", 32'(imem_req), 32'd0);
            p_hold = 1'b0;
        end else begin
            if (redirect_valid) check("redir_req", 32'(imem_req), 32'd0);
            if (p_hold) begin
                check("hold_valid", 32'(fd_valid), 32'd1);
                check("hold_pc", fd_pc, p_pc);
                check("hold_insn", fd_insn, p_insn);
            end
            if (!fd_valid) begin
                check("idle_insn", fd_insn, NOP_INSN);
                check("idle_pc", fd_pc, 32'h0);
                check("idle_plus1", fd_pc_plus1, 32'h0);
            end else if (!stall && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underflow: actual pc=%h required=none", fd_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pc", fd_pc, e);
                    check("sb_insn", fd_insn, mem_word(e[ADDR_W-1:0], data_mode));
                    check("sb_plus1", fd_pc_plus1, e + 32'd1);
                    pops++;
                end
            end
            p_hold = fd_valid && stall && !redirect_valid;
            p_pc   = fd_pc;
            p_insn = fd_insn;
        end
    end

    initial begin
        int first;
        int nvalid;
        int p0;

        // 1-cycle memory returning its address: one insn per two cycles, first at cycle 2.
        data_mode = 0;
        lat = 1;
        do_reset(3);
        first = -1;
        nvalid = 0;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            if (k == 0) begin
                check("t1_req0", 32'(last_req), 32'd1);
                check("t1_addr0", 32'(last_addr), 32'd0);
            end
            if (last_valid && first < 0) first = k;
            if (last_valid) nvalid++;
        end
        check("t1_first_valid", 32'(first), 32'd2);
        check("t1_rate", 32'(nvalid), 32'd9);

        // Stall from the start: buffer fills, requests stop, head stays at pc 0.
        data_mode = 1;
        do_reset(2);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            if (k >= 5) begin
                check("t2_req_off", 32'(last_req), 32'd0);
                check("t2_valid", 32'(last_valid), 32'd1);
                check("t2_head_pc", last_pc, 32'h0);
                check("t2_head_insn", last_insn, mem_word(12'h0, 1));
            end
        end
        for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 32'h0, 1'b0);

        // Redirect while the read for pc 5 is in flight (3-cycle memory).
        lat = 3;
        do_reset(2);
        wait_req(12'h5, "t3_req5");
        step(1'b0, 1'b1, 32'h40, 1'b0);
        wait_valid("t3_after_redir", 32'h40);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 32'h0, 1'b0);

        // Redirect coinciding with the response for pc 3, with stall high.
        lat = 2;
        do_reset(2);
        wait_req(12'h3, "t4_req3");
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h123, 1'b1);
        check("t4_coincide", 32'(last_rvalid), 32'd1);
        wait_valid("t4_after_redir", 32'h123);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 32'h0, 1'b0);

        // PC wrap at the top of the address space.
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        wait_valid("t5_wrap", 32'hFFFF_FFFF);
        check("t5_plus1", last_plus1, 32'h0);
        for (int k = 0; k < 12; k++) step(1'b0, 1'b0, 32'h0, 1'b0);

        // Reset with a read in flight; its response lands in the first cycle after reset.
        lat = 3;
        do_reset(2);
        wait_req(12'h2, "t6_req2");
        lat = 1;
        do_reset(2);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check("t6_stale_rvalid", 32'(last_rvalid), 32'd1);
        check("t6_req_after_rst", 32'(last_req), 32'd1);
        wait_valid("t6_first", 32'h0);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 32'h0, 1'b0);

        // Randomized stall, redirect and memory latency.
        do_reset(2);
        p0 = pops;
        for (int k = 0; k < 3000; k++) begin
            logic        st;
            logic        rv;
            logic [31:0] rpc;
            lat = int'($urandom_range(1, 4));
            st  = ($urandom % 4) == 0;
            rv  = ($urandom % 24) == 0;
            rpc = (($urandom % 4) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 3))) : $urandom;
            step(1'b0, rv, rpc, st);
        end
        check("rand_progress", 32'((pops - p0) > 300), 32'd1);

        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clock);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage that drives the imem port and feeds the decode stage (insn type decoder) with {insn, pc}.
- Holds the PC, allows one outstanding variable-latency imem read, and buffers returned words in a DEPTH-entry FIFO.
- Supports decode-stage stall and branch/jump redirect.
- When nothing valid is available, presents NOP (32'h0) so the decoder classifies the slot as no-op.

Parameters:
- ADDR_W, 12, imem word-address width; imem_addr = pc[ADDR_W-1:0].
- DEPTH, 2, instruction buffer entries; must be ≥1.

Ports:
- clock  input  1  sole clock; all state updates on posedge.
- reset  input  1  synchronous, active-high.
- imem_req  output  1  read request; accepted unconditionally by memory in the cycle it is high.
- imem_addr  output  ADDR_W  word address of the request.
- imem_rvalid  input  1  read data valid; at most one per accepted request; ≥1 cycle after the request.
- imem_rdata  input  32  instruction word, qualified by imem_rvalid.
- redirect_valid  input  1  control-flow change from a later stage.
- redirect_pc  input  32  new fetch PC (word address).
- stall  input  1  decode cannot accept this cycle.
- fd_valid  output  1  fd_insn/fd_pc hold a real instruction.
- fd_insn  output  32  head instruction; 32'h0 when fd_valid=0.
- fd_pc  output  32  PC of the head instruction; 0 when fd_valid=0.
- fd_pc_plus1  output  32  fd_pc+1 (mod 2^32); 0 when fd_valid=0.

Behaviour:
- Reset (synchronous): pc=0, FIFO empty, outstanding=0, discard=0. Outputs: fd_valid=0, fd_insn=0, fd_pc=0, fd_pc_plus1=0, imem_req=0 in the reset cycle.
- Issue rule (combinational): imem_req = !reset && !outstanding && !redirect_valid && (count + 0 < DEPTH).
  - Because at most one request is outstanding, count+outstanding ≤ DEPTH always holds, so the FIFO never overflows.
  - On issue: imem_addr=pc[ADDR_W-1:0]; next cycle outstanding=1 and pc=pc+1, with 32-bit wrap (0xFFFFFFFF→0).
- Response: on imem_rvalid with outstanding=1, clear outstanding.
  - If discard=0, push {pc_of_request, imem_rdata}. pc_of_request is registered at issue.
  - If discard=1, drop the word and clear discard.
  - imem_rvalid with outstanding=0 is ignored.
- Output: fd_valid = FIFO non-empty. fd_insn/fd_pc come from the FIFO head; they are forced to 0 when empty.
  - Latency: rvalid in cycle N → fd_valid in cycle N+1.
  - Best case from reset release: req at cycle 0, rvalid at 1, fd_valid at 2.
- Pop: when fd_valid && !stall && !redirect_valid. Push and pop in the same cycle is legal; count is unchanged.
- Redirect (highest priority, ignores stall):
  - Next cycle: pc=redirect_pc, FIFO flushed (count=0), no pop.
  - If a request is outstanding and its rvalid is not in this same cycle, set discard=1.
  - An rvalid coinciding with redirect_valid is dropped.
  - No imem_req in the redirect cycle; fetch resumes the following cycle (or after the discarded response returns).
- Redirect during reset: reset wins.
- Stall with full FIFO: head held stable, imem_req=0, PC frozen.
- Reset mid-flight: outstanding cleared, so a late rvalid from a pre-reset request is ignored.

Decomposition:
- Package fetch_pkg holds:
  - NOP_INSN = 32'h0
  - PC_RESET = 32'h0
  - fetch_entry_t struct {insn[31:0], pc[31:0]}
- Sub-module insn_fifo: synchronous DEPTH-entry FIFO of fetch_entry_t.
  - Inputs: push, pop, flush.
  - Outputs: head, count, full, empty.
  - Flush has priority over push/pop.
- fetch_stage contains the PC, outstanding/discard flags and issue/redirect logic.

Test Plan:
- 1-cycle memory, stall=0, imem returns addr as data: fd_insn = 0,1,2,3… with fd_pc matching. One instruction per 2 cycles (single outstanding), fd_valid first at cycle 2.
- stall held high 10 cycles after first fetch: FIFO fills to DEPTH=2, then imem_req=0. Head stays insn@pc0; on release, pcs 0,1,2 emerge in order with no loss or duplication.
- Redirect to 0x40 while a request to pc 5 is outstanding (3-cycle latency): word for pc 5 discarded, FIFO flushed, next fd_pc=0x40. No fd output with pc 5.
- redirect_valid coinciding with rvalid for pc 3, plus stall=1: word dropped, stall ignored, next fd_pc=redirect_pc.
- redirect_pc=0xFFFFFFFF: fd_pc sequence 0xFFFFFFFF, 0x0, and fd_pc_plus1=0x0 for the first entry.
- Reset asserted with a request outstanding, rvalid arrives 1 cycle after reset deassert: word ignored, first fd_pc=0, all outputs 0 during reset.
